// File: rtl/wb_stage.sv
// wb_stage: write-back stage in front of the 8x16 register file, with EX forwarding
// taps, a halt/drain FSM and a retire counter. Optional write-through bypass: WB_BYPASS_EN.
module wb_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rd,
  input  logic          in_reg_wr,
  input  logic [1:0]    in_wb_sel,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_mem,
  input  logic [DW-1:0] in_pc2,
  input  logic [DW-1:0] in_imm,
  input  logic          in_halt,
  input  logic          mem_busy,
  output logic [RW-1:0] writeRegSel,
  output logic [DW-1:0] writeData,
  output logic          writeEn,
  output logic          fwd_valid,
  output logic          halted,
  output logic [15:0]   retire_cnt,
  output logic          err
`ifdef WB_BYPASS_EN
  ,
  input  logic [RW-1:0] rb_sel1,
  input  logic [RW-1:0] rb_sel2,
  input  logic [DW-1:0] rb_in1,
  input  logic [DW-1:0] rb_in2,
  output logic [DW-1:0] rb_out1,
  output logic [DW-1:0] rb_out2
`endif
);

  // state  | meaning
  // RUN    | normal operation: capture, write rf, retire
  // DRAIN  | HALT retired, waiting for the cache to go idle
  // HALTED | stopped until reset; input refused
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wbStateT;

  wbStateT state;
  wbStateT stateNext;

  logic          vQ;
  logic [RW-1:0] rdQ;
  logic          regWrQ;
  logic [1:0]    wbSelQ;
  logic [DW-1:0] aluQ;
  logic [DW-1:0] memQ;
  logic [DW-1:0] pc2Q;
  logic [DW-1:0] immQ;
  logic          haltQ;
  logic [15:0]   retireCnt;
  logic          errQ;
  logic          running;

  assign running  = (state == RUN);
  assign in_ready = (state != HALTED);

  // Stage registers load every edge while accepting; a bubble simply clears vQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vQ     <= 1'b0;
      rdQ    <= '0;
      regWrQ <= 1'b0;
      wbSelQ <= 2'd0;
      aluQ   <= '0;
      memQ   <= '0;
      pc2Q   <= '0;
      immQ   <= '0;
      haltQ  <= 1'b0;
    end else if (in_ready) begin
      vQ     <= in_valid;
      rdQ    <= in_rd;
      regWrQ <= in_reg_wr;
      wbSelQ <= in_wb_sel;
      aluQ   <= in_alu;
      memQ   <= in_mem;
      pc2Q   <= in_pc2;
      immQ   <= in_imm;
      haltQ  <= in_halt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (vQ && haltQ) begin
          stateNext = mem_busy ? DRAIN : HALTED;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          stateNext = HALTED;
        end
      end
      HALTED:  stateNext = HALTED;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retireCnt <= 16'd0;
    end else if (vQ && running) begin
      retireCnt <= retireCnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errQ <= 1'b0;
    end else if ((state == HALTED) && in_valid) begin
      errQ <= 1'b1;
    end
  end

  always_comb begin
    writeData = aluQ;
    case (wbSelQ)
      2'd0:    writeData = aluQ;
      2'd1:    writeData = memQ;
      2'd2:    writeData = pc2Q;
      2'd3:    writeData = immQ;
      default: writeData = aluQ;
    endcase
  end

  assign writeEn     = vQ && regWrQ && running;
  assign writeRegSel = rdQ;
  assign fwd_valid   = writeEn;
  assign halted      = (state == HALTED);
  assign retire_cnt  = retireCnt;
  assign err         = errQ;

`ifdef WB_BYPASS_EN
  // Same-cycle write-through so readers see the value the rf is about to take.
  assign rb_out1 = (writeEn && (writeRegSel == rb_sel1)) ? writeData : rb_in1;
  assign rb_out2 = (writeEn && (writeRegSel == rb_sel2)) ? writeData : rb_in2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scenarios plus randomized traffic against a cycle-level
// reference of the write-back stage. Build with WB_BYPASS_EN to cover the bypass ports.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rd;
  logic        in_reg_wr;
  logic [1:0]  in_wb_sel;
  logic [15:0] in_alu;
  logic [15:0] in_mem;
  logic [15:0] in_pc2;
  logic [15:0] in_imm;
  logic        in_halt;
  logic        mem_busy;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic        fwd_valid;
  logic        halted;
  logic [15:0] retire_cnt;
  logic        err;
`ifdef WB_BYPASS_EN
  logic [2:0]  rb_sel1;
  logic [2:0]  rb_sel2;
  logic [15:0] rb_in1;
  logic [15:0] rb_in2;
  logic [15:0] rb_out1;
  logic [15:0] rb_out2;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // reference state
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;
  int          mState;
  bit          mV;
  bit          mWr;
  bit          mHalt;
  logic [2:0]  mRd;
  logic [15:0] mData;
  int          mRetire;
  bit          mErr;

  wb_stage #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_reg_wr(in_reg_wr),
    .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_mem(in_mem), .in_pc2(in_pc2),
    .in_imm(in_imm), .in_halt(in_halt), .mem_busy(mem_busy),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .fwd_valid(fwd_valid), .halted(halted), .retire_cnt(retire_cnt), .err(err)
`ifdef WB_BYPASS_EN
    , .rb_sel1(rb_sel1), .rb_sel2(rb_sel2), .rb_in1(rb_in1), .rb_in2(rb_in2),
    .rb_out1(rb_out1), .rb_out2(rb_out2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compareAll();
    bit expWe;
    expWe = mV && mWr && (mState == M_RUN);
    checkEq("writeEn", writeEn, expWe);
    checkEq("fwd_valid", fwd_valid, expWe);
    checkEq("writeRegSel", writeRegSel, mRd);
    checkEq("writeData", writeData, mData);
    checkEq("in_ready", in_ready, mState != M_HALTED);
    checkEq("halted", halted, mState == M_HALTED);
    checkEq("retire_cnt", retire_cnt, mRetire[15:0]);
    checkEq("err", err, mErr);
`ifdef WB_BYPASS_EN
    checkEq("rb_out1", rb_out1, (expWe && rb_sel1 == mRd) ? mData : rb_in1);
    checkEq("rb_out2", rb_out2, (expWe && rb_sel2 == mRd) ? mData : rb_in2);
`endif
  endtask

  // Called in the low clock phase; applies one instruction, takes one edge,
  // advances the reference and optionally compares, then returns at the next negedge.
  task automatic step(input bit v, input logic [2:0] rd, input bit wr, input logic [1:0] sel,
                      input logic [15:0] a, input logic [15:0] m, input logic [15:0] p,
                      input logic [15:0] i, input bit h, input bit b, input bit chk);
    logic [15:0] vals[4];
    int os;
    in_valid = v; in_rd = rd; in_reg_wr = wr; in_wb_sel = sel;
    in_alu = a; in_mem = m; in_pc2 = p; in_imm = i; in_halt = h; mem_busy = b;
    @(posedge clk);
    os = mState;
    if (os == M_RUN) begin
      if (mV) begin
        mRetire = (mRetire + 1) % 65536;
        if (mHalt) mState = b ? M_DRAIN : M_HALTED;
      end
    end else if (os == M_DRAIN) begin
      if (!b) mState = M_HALTED;
    end else if (v) begin
      mErr = 1'b1;
    end
    if (os != M_HALTED) begin
      vals = '{a, m, p, i};
      mV = v; mRd = rd; mWr = wr; mHalt = h; mData = vals[sel];
    end
    #1;
    if (chk) compareAll();
    @(negedge clk);
  endtask

  task automatic doReset();
    in_valid = 1'b0; in_rd = '0; in_reg_wr = 1'b0; in_wb_sel = '0;
    in_alu = '0; in_mem = '0; in_pc2 = '0; in_imm = '0; in_halt = 1'b0; mem_busy = 1'b0;
    rst = 1'b1;
    #1;
    mState = M_RUN; mV = 0; mWr = 0; mHalt = 0; mRd = '0; mData = '0; mRetire = 0; mErr = 0;
    checkEq("rst_writeEn", writeEn, 1'b0);
    checkEq("rst_fwd_valid", fwd_valid, 1'b0);
    checkEq("rst_writeRegSel", writeRegSel, 3'd0);
    checkEq("rst_writeData", writeData, 16'h0000);
    checkEq("rst_in_ready", in_ready, 1'b1);
    checkEq("rst_halted", halted, 1'b0);
    checkEq("rst_retire_cnt", retire_cnt, 16'h0000);
    checkEq("rst_err", err, 1'b0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    rb_sel1 = 3'd0; rb_sel2 = 3'd0; rb_in1 = 16'h0; rb_in2 = 16'h0;
`endif
    rst = 1'b1;
    in_valid = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    doReset();

    // ALU write lands one cycle after capture; retires on the following edge
    step(1, 3'd3, 1, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t1_we", writeEn, 1'b1);
    checkEq("t1_sel", writeRegSel, 3'd3);
    checkEq("t1_data", writeData, 16'h1234);
    step(0, 3'd0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t1_retire", retire_cnt, 16'd1);
    checkEq("t1_bubble_we", writeEn, 1'b0);

    // each write-back source back to back
    step(1, 3'd1, 1, 2'd1, 16'h1111, 16'hBEEF, 16'h2222, 16'h3333, 0, 0, 1);
    checkEq("t2_mem", writeData, 16'hBEEF);
    step(1, 3'd2, 1, 2'd2, 16'h1111, 16'h4444, 16'h0102, 16'h3333, 0, 0, 1);
    checkEq("t2_pc2", writeData, 16'h0102);
    step(1, 3'd4, 1, 2'd3, 16'h1111, 16'h4444, 16'h5555, 16'hFFF0, 0, 0, 1);
    checkEq("t2_imm", writeData, 16'hFFF0);

    // store (no reg write) retires without writing; bubble does neither
    step(1, 3'd6, 0, 2'd0, 16'hAAAA, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t3_store_we", writeEn, 1'b0);
    checkEq("t3_retire_a", retire_cnt, 16'd4);
    step(0, 3'd0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t3_bubble_we", writeEn, 1'b0);
    checkEq("t3_retire_b", retire_cnt, 16'd5);
    step(0, 3'd0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t3_retire_c", retire_cnt, 16'd5);

`ifdef WB_BYPASS_EN
    step(1, 3'd5, 1, 2'd0, 16'h00AA, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    rb_sel1 = 3'd5; rb_in1 = 16'h0000; rb_sel2 = 3'd4; rb_in2 = 16'h1357;
    #1;
    checkEq("t6_rb_out1", rb_out1, 16'h00AA);
    checkEq("t6_rb_out2", rb_out2, 16'h1357);
    @(negedge clk);
`endif

    // HALT with cache busy: three DRAIN cycles, then HALTED
    doReset();
    step(1, 3'd7, 1, 2'd0, 16'h0777, 16'h0, 16'h0, 16'h0, 1, 1, 1);
    checkEq("t4_halt_we", writeEn, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(0, 3'd0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 1);
      checkEq("t4_drain_halted", halted, 1'b0);
      checkEq("t4_drain_ready", in_ready, 1'b1);
      checkEq("t4_drain_we", writeEn, 1'b0);
    end
    step(0, 3'd0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t4_halted", halted, 1'b1);
    checkEq("t4_ready", in_ready, 1'b0);
    checkEq("t4_retire", retire_cnt, 16'd1);
    step(1, 3'd2, 1, 2'd0, 16'h9999, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t4_err", err, 1'b1);
    checkEq("t4_err_we", writeEn, 1'b0);

    // retire counter wrap, then reset in the middle of a write
    doReset();
    for (int k = 0; k < 65536; k++) begin
      step(1, 3'd1, 1, 2'd0, k[15:0], 16'h0, 16'h0, 16'h0, 0, 0, 0);
    end
    checkEq("t5_ffff", retire_cnt, 16'hFFFF);
    step(1, 3'd2, 1, 2'd0, 16'hCAFE, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    checkEq("t5_wrap", retire_cnt, 16'h0000);
    checkEq("t5_pre_rst_we", writeEn, 1'b1);
    doReset();

    // randomized traffic, several halt episodes
    for (int ep = 0; ep < 6; ep++) begin
      for (int c = 0; c < 300; c++) begin
        bit rv;
        rv = ($urandom_range(0, 3) != 0);
        if (mState == M_DRAIN) rv = 0;
        if (mState == M_HALTED) rv = ($urandom_range(0, 7) == 0);
`ifdef WB_BYPASS_EN
        rb_sel1 = 3'($urandom); rb_sel2 = 3'($urandom);
        rb_in1 = 16'($urandom); rb_in2 = 16'($urandom);
`endif
        step(rv, 3'($urandom), bit'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), ($urandom_range(0, 59) == 0),
             bit'($urandom), 1);
      end
      doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
